// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC sequencer with ID-stage branch/jump redirect.
// Branch decode happens in ID; a taken transfer loads the target into the
// fetch PC. If the hazard unit is stalling when the transfer resolves, the
// target is parked in r_pend_pc and applied once the stall releases.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic        cmp_result,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic        pc_ce,
    output logic        redirect,
    output logic        addr_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] w_next_pend_pc;
    logic        r_pc_ce;
    logic        r_redirect;
    logic        r_addr_err;
    logic        w_load;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_cond;
    logic        w_is_abs;
    logic        w_is_reg;
    logic        w_take;
    logic [31:0] w_id_pc4;
    logic [31:0] w_br_offset;
    logic [31:0] w_target;

    assign w_opcode    = id_instr[31:26];
    assign w_funct     = id_instr[5:0];
    assign w_id_pc4    = id_pc + 32'd4;
    assign w_br_offset = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

    // Decode the control-transfer class and pick its target address.
    always_comb begin
        w_is_cond = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                    (w_opcode == OP_BGTZ) || (w_opcode == OP_REGIMM);
        w_is_abs  = (w_opcode == OP_J) || (w_opcode == OP_JAL);
        w_is_reg  = (w_opcode == OP_SPECIAL) &&
                    ((w_funct == FN_JR) || (w_funct == FN_JALR));
        w_take    = id_valid && (w_is_abs || w_is_reg || (w_is_cond && cmp_result));
        if (w_is_reg) begin
            w_target = rs_data;
        end else if (w_is_abs) begin
            w_target = {w_id_pc4[31:28], id_instr[25:0], 2'b00};
        end else begin
            w_target = w_id_pc4 + w_br_offset;
        end
    end

    // Next-state and next-PC selection; ID inputs only matter in RUN.
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_pend_pc = r_pend_pc;
        w_load         = 1'b0;
        case (r_state)
            RUN: begin
                if (!stall) begin
                    if (w_take) begin
                        w_next_pc = w_target;
                        w_load    = 1'b1;
                    end else begin
                        w_next_pc = r_pc + 32'd4;
                    end
                end else if (w_take) begin
                    w_next_pend_pc = w_target;
                    w_next_state   = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_next_pc    = r_pend_pc;
                    w_load       = 1'b1;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // State register; reset always returns to RUN and drops any pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered fetch outputs and pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pc_ce    <= 1'b0;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
            r_pend_pc  <= 32'd0;
        end else begin
            r_pc       <= w_next_pc;
            r_pc_ce    <= 1'b1;
            r_redirect <= w_load;
            r_addr_err <= r_addr_err | (w_load & (w_next_pc[1:0] != 2'b00));
            r_pend_pc  <= w_next_pend_pc;
        end
    end

    assign pc       = r_pc;
    assign pc_ce    = r_pc_ce;
    assign redirect = r_redirect;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed testbench for pc_redirect_unit.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        cmp_result;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic        pc_ce;
    logic        redirect;
    logic        addr_err;

    int checks = 0;
    int fails  = 0;

    pc_redirect_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .cmp_result (cmp_result),
        .rs_data    (rs_data),
        .pc         (pc),
        .pc_ce      (pc_ce),
        .redirect   (redirect),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle 1ns past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] e_pc,
                                input logic e_ce, input logic e_redir, input logic e_err);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_ce"}, {31'd0, pc_ce}, {31'd0, e_ce});
        check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_redir});
        check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
        $display("step %-12s pc=%08h ce=%0b redirect=%0b addr_err=%0b", tag, pc, pc_ce, redirect, addr_err);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; id_valid = 1'b0; id_instr = 32'd0;
        id_pc = 32'd0; cmp_result = 1'b0; rs_data = 32'd0;
        step();
        step();
        expect_state("reset", 32'hBFC00000, 1'b0, 1'b0, 1'b0);

        // Sequential fetch after reset release
        rst = 1'b0;
        step(); expect_state("seq1", 32'hBFC00004, 1'b1, 1'b0, 1'b0);
        step(); expect_state("seq2", 32'hBFC00008, 1'b1, 1'b0, 1'b0);

        // BEQ taken: BFC00014 + 0xC
        id_valid = 1'b1; id_instr = 32'h10000003; id_pc = 32'hBFC00010; cmp_result = 1'b1;
        step(); expect_state("beq_taken", 32'hBFC00020, 1'b1, 1'b1, 1'b0);
        id_valid = 1'b0;
        step(); expect_state("after_beq", 32'hBFC00024, 1'b1, 1'b0, 1'b0);

        // BEQ not taken
        id_valid = 1'b1; cmp_result = 1'b0;
        step(); expect_state("beq_nt", 32'hBFC00028, 1'b1, 1'b0, 1'b0);

        // Non-transfer opcode ignores cmp_result
        id_instr = 32'h20000003; cmp_result = 1'b1;
        step(); expect_state("addi", 32'hBFC0002C, 1'b1, 1'b0, 1'b0);

        // Invalid ID stage ignores a branch
        id_valid = 1'b0; id_instr = 32'h10000003;
        step(); expect_state("invalid", 32'hBFC00030, 1'b1, 1'b0, 1'b0);

        // BNE backward: 0x104 - 4
        id_valid = 1'b1; id_instr = 32'h1400FFFF; id_pc = 32'h00000100; cmp_result = 1'b1;
        step(); expect_state("bne_back", 32'h00000100, 1'b1, 1'b1, 1'b0);

        // J: region B, index 0x40
        id_instr = 32'h08000040; id_pc = 32'hBFC00000; cmp_result = 1'b0;
        step(); expect_state("j_abs", 32'hB0000100, 1'b1, 1'b1, 1'b0);

        // BGTZ taken: 0x4 + 0x8
        id_instr = 32'h1C000002; id_pc = 32'h00000000; cmp_result = 1'b1;
        step(); expect_state("bgtz", 32'h0000000C, 1'b1, 1'b1, 1'b0);

        // BLTZ (REGIMM) not taken
        id_instr = 32'h04000010; cmp_result = 1'b0;
        step(); expect_state("bltz_nt", 32'h00000010, 1'b1, 1'b0, 1'b0);

        // JAL: id_pc 0x1FFFFFFC -> pc+4 = 0x20000000, region 2
        id_instr = 32'h0C000001; id_pc = 32'h1FFFFFFC;
        step(); expect_state("jal", 32'h20000004, 1'b1, 1'b1, 1'b0);

        // Stall without transfer: pc held
        id_valid = 1'b0; stall = 1'b1;
        step(); expect_state("stall_run", 32'h20000004, 1'b1, 1'b0, 1'b0);

        // JR under stall -> HOLD; ID changes ignored while held
        id_valid = 1'b1; id_instr = 32'h00000008; rs_data = 32'h80001000;
        step(); expect_state("jr_hold1", 32'h20000004, 1'b1, 1'b0, 1'b0);
        id_instr = 32'h08000040; rs_data = 32'h00000000; cmp_result = 1'b1;
        step(); expect_state("jr_hold2", 32'h20000004, 1'b1, 1'b0, 1'b0);
        id_instr = 32'h10000003;
        step(); expect_state("jr_hold3", 32'h20000004, 1'b1, 1'b0, 1'b0);
        stall = 1'b0; id_valid = 1'b0;
        step(); expect_state("jr_release", 32'h80001000, 1'b1, 1'b1, 1'b0);
        step(); expect_state("after_jr", 32'h80001004, 1'b1, 1'b0, 1'b0);

        // JALR to a misaligned target sets the sticky error
        id_valid = 1'b1; id_instr = 32'h00000009; rs_data = 32'h80001002; cmp_result = 1'b0;
        step(); expect_state("jalr_mis", 32'h80001002, 1'b1, 1'b1, 1'b1);
        id_valid = 1'b0;
        step(); expect_state("err_sticky", 32'h80001006, 1'b1, 1'b0, 1'b1);

        // Reset in HOLD discards the pending target
        stall = 1'b1; id_valid = 1'b1; id_instr = 32'h00000008; rs_data = 32'h12345678;
        step(); expect_state("hold_again", 32'h80001006, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; stall = 1'b0; id_valid = 1'b0;
        step(); expect_state("rst_hold", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); expect_state("post_rst", 32'hBFC00004, 1'b1, 1'b0, 1'b0);

        // Wrap at 2^32
        id_valid = 1'b1; id_instr = 32'h00000008; rs_data = 32'hFFFFFFFC;
        step(); expect_state("to_top", 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0);
        id_valid = 1'b0;
        step(); expect_state("wrap", 32'h00000000, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, SHALL set the PC value loaded on reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hazard-unit hold; 1 SHALL freeze PC.
REQ-005 id_valid  input  1  ID-stage instruction valid.
REQ-006 id_instr  input  32  ID-stage instruction word.
REQ-007 id_pc  input  32  PC of the ID-stage instruction.
REQ-008 cmp_result  input  1  branch-condition result from the ID compare unit (1 = taken).
REQ-009 rs_data  input  32  forwarded rs value for JR/JALR.
REQ-010 pc  output  32  fetch address (registered).
REQ-011 pc_ce  output  1  fetch enable (registered).
REQ-012 redirect  output  1  one-cycle pulse, registered, marking a non-sequential PC load.
REQ-013 addr_err  output  1  sticky flag: a misaligned target was loaded (registered).

Function
REQ-014 Control transfer SHALL be decoded from id_instr[31:26]:
- 000100 BEQ, 000101 BNE, 000111 BGTZ, 000001 BLTZ: conditional.
- 000010 J, 000011 JAL: absolute.
- 000000 with funct 001000 JR or 001001 JALR: register.
REQ-015 Conditional target SHALL be id_pc + 4 + (sign-extended id_instr[15:0] << 2), mod 2^32.
REQ-016 Absolute target SHALL be {(id_pc+4)[31:28], id_instr[25:0], 2'b00}.
REQ-017 Register target SHALL be rs_data unmodified.
REQ-018 take SHALL be id_valid AND (absolute OR register OR (conditional AND cmp_result)).
REQ-019 With id_valid=0 or a non-transfer opcode, cmp_result SHALL be ignored.
REQ-020 FSM states: RUN, HOLD. In RUN, stall=0, take=0: pc <= pc+4 (wraps at 2^32).
REQ-021 In RUN, stall=0, take=1: pc <= target; redirect=1 next cycle.
REQ-022 Instruction at id_pc+4 is the delay slot; it SHALL be fetched normally, never squashed.
REQ-023 In RUN, stall=1, take=0: pc held; state stays RUN.
REQ-024 In RUN, stall=1, take=1: pc held, target latched into pend_pc, state -> HOLD.
REQ-025 In HOLD, ID inputs SHALL be ignored; while stall=1, pc and pend_pc are held.
REQ-026 In HOLD, stall=0: pc <= pend_pc, redirect=1 next cycle, state -> RUN.
REQ-027 Latency: redirect-to-new-pc SHALL be exactly one cycle after the first cycle with take=1 and stall=0 (RUN) or stall falling (HOLD).
REQ-028 redirect SHALL be 0 in every cycle it is not loading a target per REQ-021/026.
REQ-029 Any loaded target with bits [1:0] != 2'b00 SHALL set addr_err; cleared only by reset.
REQ-030 pc_ce SHALL be 0 during reset and 1 from the first cycle after rst deasserts.

Reset
REQ-031 rst=1 at an edge SHALL set pc=RESET_PC, pc_ce=0, redirect=0, addr_err=0, pend_pc=0, state=RUN; overrides stall and take.
REQ-032 Reset mid-HOLD SHALL discard the pending target; first fetch after reset is RESET_PC.

Verification
REQ-033 Reset release, stall=0, no branches -> pc = BFC00000, BFC00004, BFC00008; pc_ce 0 then 1.
REQ-034 BEQ imm=16'h0003, id_pc=BFC00010, cmp_result=1, stall=0 -> next pc=BFC00020, redirect pulse 1 cycle; cmp_result=0 -> pc+4.
REQ-035 BNE imm=16'hFFFF, id_pc=00000100, taken -> pc=00000100; J instr_index=26'h0000040, id_pc=BFC00000 -> pc=B0000100.
REQ-036 JR rs_data=80001000 with stall=1 for 3 cycles -> pc frozen, no redirect; stall drop -> pc=80001000 next cycle, redirect 1; ID inputs changed during HOLD have no effect.
REQ-037 JR rs_data=80001002 -> pc=80001002, addr_err=1 and stays 1; rst asserted while HOLD -> pc=BFC00000, addr_err=0.
REQ-038 pc=FFFFFFFC, no branch, stall=0 -> pc wraps to 00000000.
